// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon-MM master between instruction-fetch and data ports.
// One transfer at a time: IDLE -> ISSUE (held under waitrequest) -> RESP.
module avalon_bus_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_ack,
  output logic [31:0] i_readdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state, state_n;

  logic        gnt_d, gnt_d_n;
  logic        last_d, last_d_n;
  logic        pick_d;
  logic [31:0] address_n;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata_n;
  logic [3:0]  byteenable_n;
  logic        i_ack_n;
  logic        d_ack_n;
  logic [31:0] i_rd_n;
  logic [31:0] d_rd_n;

  // Data wins alone, on fixed priority, or when instruction had the last turn.
  assign pick_d = d_req &&
                  (!i_req || !ROUND_ROBIN || !last_d);

  always_comb begin
    state_n      = state;
    gnt_d_n      = gnt_d;
    last_d_n     = last_d;
    address_n    = address;
    read_n       = read;
    write_n      = write;
    writedata_n  = writedata;
    byteenable_n = byteenable;
    i_ack_n      = 1'b0;
    d_ack_n      = 1'b0;
    i_rd_n       = i_readdata;
    d_rd_n       = d_readdata;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_n  = ISSUE;
          gnt_d_n  = pick_d;
          last_d_n = pick_d;
          if (pick_d) begin
            address_n    = d_address;
            read_n       = !d_write;
            write_n      = d_write;
            byteenable_n = d_write ? d_byteenable : 4'hF;
            writedata_n  = d_write ? d_writedata : 32'h0;
          end else begin
            address_n    = i_address;
            read_n       = 1'b1;
            write_n      = 1'b0;
            byteenable_n = 4'hF;
            writedata_n  = 32'h0;
          end
        end
      end
      ISSUE: begin
        if (!waitrequest) begin
          if (read) begin
            if (gnt_d) d_rd_n = readdata;
            else       i_rd_n = readdata;
          end
          address_n    = 32'h0;
          read_n       = 1'b0;
          write_n      = 1'b0;
          writedata_n  = 32'h0;
          byteenable_n = 4'h0;
          i_ack_n      = !gnt_d;
          d_ack_n      = gnt_d;
          state_n      = RESP;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt_d      <= 1'b0;
      last_d     <= 1'b0;
      address    <= 32'h0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= 32'h0;
      byteenable <= 4'h0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_readdata <= 32'h0;
      d_readdata <= 32'h0;
    end else begin
      state      <= state_n;
      gnt_d      <= gnt_d_n;
      last_d     <= last_d_n;
      address    <= address_n;
      read       <= read_n;
      write      <= write_n;
      writedata  <= writedata_n;
      byteenable <= byteenable_n;
      i_ack      <= i_ack_n;
      d_ack      <= d_ack_n;
      i_readdata <= i_rd_n;
      d_readdata <= d_rd_n;
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter: round-robin and fixed-priority
// instances share stimulus; expected values are hand-computed.
module tb_avalon_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_address;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  logic        i_ack, d_ack, read, write;
  logic [31:0] i_readdata, d_readdata, address, writedata;
  logic [3:0]  byteenable;

  logic        fp_i_ack, fp_d_ack, fp_read, fp_write;
  logic [31:0] fp_i_readdata, fp_d_readdata, fp_address, fp_writedata;
  logic [3:0]  fp_byteenable;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  avalon_bus_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_address(i_address),
    .i_ack(i_ack), .i_readdata(i_readdata),
    .d_req(d_req), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_ack(d_ack), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  avalon_bus_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_address(i_address),
    .i_ack(fp_i_ack), .i_readdata(fp_i_readdata),
    .d_req(d_req), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_ack(fp_d_ack), .d_readdata(fp_d_readdata),
    .address(fp_address), .read(fp_read), .write(fp_write),
    .writedata(fp_writedata), .byteenable(fp_byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle(input string tag);
    chk({tag, " read"}, {31'h0, read}, 32'h0);
    chk({tag, " write"}, {31'h0, write}, 32'h0);
    chk({tag, " addr"}, address, 32'h0);
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_address = '0;
    d_req = 1'b0; d_write = 1'b0; d_address = '0;
    d_writedata = '0; d_byteenable = '0;
    waitrequest = 1'b0; readdata = '0;
    step(); step();
    bus_idle("rst");
    chk("rst be", {28'h0, byteenable}, 32'h0);
    chk("rst wdata", writedata, 32'h0);
    chk("rst acks", {30'h0, i_ack, d_ack}, 32'h0);
    chk("rst i_rd", i_readdata, 32'h0);
    chk("rst d_rd", d_readdata, 32'h0);
    reset = 1'b0;
    step();

    // fetch, no wait
    i_req = 1'b1; i_address = 32'hBFC00000; readdata = 32'h24020005;
    step();
    chk("f1 read", {31'h0, read}, 32'h1);
    chk("f1 write", {31'h0, write}, 32'h0);
    chk("f1 addr", address, 32'hBFC00000);
    chk("f1 be", {28'h0, byteenable}, 32'hF);
    chk("f1 ack", {30'h0, i_ack, d_ack}, 32'h0);
    step();
    chk("f2 acks", {30'h0, i_ack, d_ack}, 32'h2);
    chk("f2 i_rd", i_readdata, 32'h24020005);
    bus_idle("f2");
    i_req = 1'b0;
    step();
    bus_idle("f3");
    chk("f3 acks", {30'h0, i_ack, d_ack}, 32'h0);

    // data write, 3 wait cycles
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h1004;
    d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
    waitrequest = 1'b1; readdata = 32'hAAAA5555;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("w%0d write", k), {31'h0, write}, 32'h1);
      chk($sformatf("w%0d read", k), {31'h0, read}, 32'h0);
      chk($sformatf("w%0d addr", k), address, 32'h1004);
      chk($sformatf("w%0d wdata", k), writedata, 32'hDEADBEEF);
      chk($sformatf("w%0d be", k), {28'h0, byteenable}, 32'h3);
      chk($sformatf("w%0d ack", k), {30'h0, i_ack, d_ack}, 32'h0);
      if (k == 3) waitrequest = 1'b0;
    end
    step();
    chk("w ack", {30'h0, i_ack, d_ack}, 32'h1);
    chk("w d_rd", d_readdata, 32'h0);
    bus_idle("w resp");
    d_req = 1'b0;
    step();
    chk("w ack end", {30'h0, i_ack, d_ack}, 32'h0);

    // data read
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h2000;
    readdata = 32'h12345678;
    step();
    chk("r1 read", {31'h0, read}, 32'h1);
    chk("r1 write", {31'h0, write}, 32'h0);
    chk("r1 addr", address, 32'h2000);
    chk("r1 be", {28'h0, byteenable}, 32'hF);
    chk("r1 wdata", writedata, 32'h0);
    step();
    chk("r2 acks", {30'h0, i_ack, d_ack}, 32'h1);
    chk("r2 d_rd", d_readdata, 32'h12345678);
    chk("r2 i_rd", i_readdata, 32'h24020005);
    d_req = 1'b0;
    step();

    // contention from reset: data, instruction, data
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_req = 1'b1; i_address = 32'h100;
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h200;
    for (int t = 0; t < 3; t++) begin
      readdata = 32'hC0DE0000 + t;
      step();
      chk($sformatf("rr%0d addr", t), address,
          (t == 1) ? 32'h100 : 32'h200);
      step();
      chk($sformatf("rr%0d acks", t), {30'h0, i_ack, d_ack},
          (t == 1) ? 32'h2 : 32'h1);
      if (t == 1) chk("rr i_rd", i_readdata, 32'hC0DE0001);
      else chk($sformatf("rr%0d d_rd", t), d_readdata, 32'hC0DE0000 + t);
      if (t == 2) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      step();
      chk($sformatf("rr%0d idle", t), {30'h0, i_ack, d_ack}, 32'h0);
    end

    // fixed priority: data every time until d_req drops
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      chk($sformatf("fp%0d addr", t), fp_address,
          (t == 3) ? 32'h100 : 32'h200);
      step();
      chk($sformatf("fp%0d acks", t), {30'h0, fp_i_ack, fp_d_ack},
          (t == 3) ? 32'h2 : 32'h1);
      if (t == 2) d_req = 1'b0;
      if (t == 3) i_req = 1'b0;
      step();
    end

    // reset while a write is stalled
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h3000;
    d_writedata = 32'h55AA55AA; d_byteenable = 4'hC;
    waitrequest = 1'b1;
    step();
    chk("rs write", {31'h0, write}, 32'h1);
    reset = 1'b1;
    step();
    bus_idle("rs");
    chk("rs wdata", writedata, 32'h0);
    chk("rs be", {28'h0, byteenable}, 32'h0);
    reset = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    step();
    chk("rs noack1", {30'h0, i_ack, d_ack}, 32'h0);
    step();
    chk("rs noack2", {30'h0, i_ack, d_ack}, 32'h0);
    i_req = 1'b1; i_address = 32'h4000; readdata = 32'h0BADF00D;
    step();
    chk("rs f1 read", {31'h0, read}, 32'h1);
    chk("rs f1 addr", address, 32'h4000);
    step();
    chk("rs f2 ack", {30'h0, i_ack, d_ack}, 32'h2);
    chk("rs f2 i_rd", i_readdata, 32'h0BADF00D);
    i_req = 1'b0;
    step();
    bus_idle("rs f3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
